// File: rtl/fp16_seq_if.sv
// Operation request and result bundle for the fp16 add/multiply sequencer.
// The master drives the request side; the slave returns result, status and flags.
interface fp16_seq_if;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        unf;

  modport master (
    output start, op, a, b,
    input  result, busy, done, ovf, unf
  );

  modport slave (
    input  start, op, a, b,
    output result, busy, done, ovf, unf
  );
endinterface

// File: rtl/fp16_seq.sv
// Multicycle binary16 add/multiply: align, execute, one-bit-per-cycle normalise, pack.
// Latency 4+k cycles (2 on zero bypass); start is ignored while busy, nothing is queued.
module fp16_seq (
  input  logic         clk,
  input  logic         reset,
  fp16_seq_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic               op_q, op_d;
  logic               sign_q, sign_d;
  logic               sub_q, sub_d;
  logic signed [6:0]  e_q, e_d;
  logic [10:0]        ml_q, ml_d;
  logic [10:0]        ms_q, ms_d;
  logic [11:0]        m_q, m_d;
  logic [15:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic        sa, sb;
  logic [4:0]  ea, eb;
  logic [10:0] ma, mb;
  logic        a_zero, b_zero, any_zero;
  logic        a_is_l;
  logic        sl;
  logic [4:0]  el, es, sh;
  logic [10:0] mlw, msw, ms_sh;
  logic [11:0] m_sum, m_dif, prod_hi;
  logic        norm_done;

  // Unpack and order operands from the captured registers.
  assign sa       = a_q[15];
  assign sb       = b_q[15];
  assign ea       = a_q[14:10];
  assign eb       = b_q[14:10];
  assign ma       = {1'b1, a_q[9:0]};
  assign mb       = {1'b1, b_q[9:0]};
  assign a_zero   = (ea == 5'd0);
  assign b_zero   = (eb == 5'd0);
  assign any_zero = a_zero | b_zero;
  assign a_is_l   = (a_q[14:0] >= b_q[14:0]);
  assign sl       = a_is_l ? sa : sb;
  assign el       = a_is_l ? ea : eb;
  assign es       = a_is_l ? eb : ea;
  assign mlw      = a_is_l ? ma : mb;
  assign msw      = a_is_l ? mb : ma;
  assign sh       = el - es;
  assign ms_sh    = (sh >= 5'd11) ? 11'd0 : (msw >> sh);

  // For multiply, ml_q/ms_q hold ma/mb; the product keeps bits [21:10].
  assign m_sum    = {1'b0, ml_q} + {1'b0, ms_q};
  assign m_dif    = {1'b0, ml_q} - {1'b0, ms_q};
  assign prod_hi  = 12'((22'(ml_q) * 22'(ms_q)) >> 10);

  assign norm_done = (m_q == 12'd0) || (!m_q[11] && m_q[10]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ALIGN;
      ALIGN:   state_d = any_zero ? DONE : EXEC;
      EXEC:    state_d = NORM;
      NORM:    if (norm_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sign_d   = sign_q;
    sub_d    = sub_q;
    e_d      = e_q;
    ml_d     = ml_q;
    ms_d     = ms_q;
    m_d      = m_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          op_d  = bus.op;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
      end
      ALIGN: begin
        if (any_zero) begin
          if (op_q)        result_d = {sa ^ sb, 15'b0};
          else if (a_zero) result_d = b_q;
          else             result_d = a_q;
        end else if (op_q) begin
          e_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
          sign_d = sa ^ sb;
          ml_d   = ma;
          ms_d   = mb;
        end else begin
          e_d    = $signed({2'b00, el});
          sign_d = sl;
          sub_d  = sa ^ sb;
          ml_d   = mlw;
          ms_d   = ms_sh;
        end
      end
      EXEC: begin
        if (op_q)       m_d = prod_hi;
        else if (sub_q) m_d = m_dif;
        else            m_d = m_sum;
      end
      NORM: begin
        if (m_q == 12'd0) begin
          result_d = 16'h0000;
        end else if (m_q[11]) begin
          m_d = m_q >> 1;
          e_d = e_q + 7'sd1;
        end else if (!m_q[10]) begin
          m_d = m_q << 1;
          e_d = e_q - 7'sd1;
        end else if (e_q >= 7'sd31) begin
          result_d = {sign_q, 5'h1F, 10'h000};
          ovf_d    = 1'b1;
        end else if (e_q <= 7'sd0) begin
          result_d = {sign_q, 15'b0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_q[4:0], m_q[9:0]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      e_q      <= 7'sd0;
      ml_q     <= 11'd0;
      ms_q     <= 11'd0;
      m_q      <= 12'd0;
      result_q <= 16'h0000;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      sub_q    <= sub_d;
      e_q      <= e_d;
      ml_q     <= ml_d;
      ms_q     <= ms_d;
      m_q      <= m_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule
